inst_prefetch_queue: RTL and testbench

//  Parametrised instruction prefetch queue between the instruction-memory (APB) fetch port and decode.

---
 rtl/nq_pfq_pkg.sv | 32 +++
 rtl/pfq_ram.sv | 39 +++
 rtl/inst_prefetch_queue.sv | 135 +++++++++++++
 tb/tb_inst_prefetch_queue.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nq_pfq_pkg.sv
// ============================================================================
// Package : nq_pfq_pkg
// Brief   : Shared constants, width helpers and entry type for the prefetch queue.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package nq_pfq_pkg;

  localparam int unsigned PFQ_INST_W     = 16;
  localparam int unsigned PFQ_PC_W       = 32;
  localparam int unsigned PFQ_FETCH_W    = 2;
  localparam int unsigned PFQ_DEPTH      = 8;
  localparam int unsigned PFQ_INST_BYTES = 2;

  function automatic int unsigned pfq_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned pfq_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Entry layout for the default configuration; storage uses the same {pc, inst} packing.
  typedef struct packed {
    logic [PFQ_PC_W-1:0]   pc;
    logic [PFQ_INST_W-1:0] inst;
  } pfq_entry_t;

endpackage

`default_nettype wire

// File: rtl/pfq_ram.sv
// ============================================================================
// Module : pfq_ram
// Brief  : DEPTH x WIDTH storage with LANES write ports and one async read port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pfq_ram
  import nq_pfq_pkg::*;
#(
  parameter int unsigned DEPTH = PFQ_DEPTH,
  parameter int unsigned WIDTH = PFQ_INST_W + PFQ_PC_W,
  parameter int unsigned LANES = PFQ_FETCH_W,
  parameter int unsigned AW    = pfq_ptr_w(PFQ_DEPTH)
) (
  input  logic                   clk,
  input  logic [LANES-1:0]       we_i,
  input  logic [LANES*AW-1:0]    waddr_i,
  input  logic [LANES*WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]          raddr_i,
  output logic [WIDTH-1:0]       rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Lanes of one beat always target distinct entries, so write order is irrelevant.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (we_i[i]) begin
        mem_q[waddr_i[i*AW +: AW]] <= wdata_i[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/inst_prefetch_queue.sv
// ============================================================================
// Module : inst_prefetch_queue
// Brief  : Instruction prefetch queue, FETCH_W-wide push, one-per-cycle pop.
//          Define PFQ_BYPASS_EN for same-cycle fetch-to-decode bypass when empty.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_prefetch_queue
  import nq_pfq_pkg::*;
#(
  parameter int unsigned INST_W     = PFQ_INST_W,
  parameter int unsigned PC_W       = PFQ_PC_W,
  parameter int unsigned FETCH_W    = PFQ_FETCH_W,
  parameter int unsigned DEPTH      = PFQ_DEPTH,
  parameter int unsigned INST_BYTES = PFQ_INST_BYTES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      fetch_valid,
  output logic                      fetch_ready,
  input  logic [FETCH_W*INST_W-1:0] fetch_data,
  input  logic [PC_W-1:0]           fetch_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INST_W-1:0]         out_inst,
  output logic [PC_W-1:0]           out_pc,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
);

  localparam int unsigned PTR_W = pfq_ptr_w(DEPTH);
  localparam int unsigned CNT_W = pfq_cnt_w(DEPTH);
  localparam int unsigned ENT_W = INST_W + PC_W;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push;
  logic             pop;
  logic             byp_active;
  logic             byp_take;
  logic [CNT_W-1:0] n_wr;
  logic [ENT_W-1:0] head_ent;

  logic [FETCH_W-1:0]       lane_we;
  logic [FETCH_W*PTR_W-1:0] lane_addr;
  logic [FETCH_W*ENT_W-1:0] lane_data;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  // Ready depends only on registered occupancy: no credit is taken for a same-cycle pop.
  assign fetch_ready = ~rst & ~flush & ((CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_W));
  assign push        = fetch_valid & fetch_ready;

`ifdef PFQ_BYPASS_EN
  assign byp_active = empty & push;
`else
  assign byp_active = 1'b0;
`endif

  assign byp_take  = byp_active & out_ready;
  assign out_valid = ~empty | byp_active;
  assign pop       = ~empty & out_ready & ~flush;
  assign n_wr      = push ? (CNT_W'(FETCH_W) - CNT_W'(byp_take)) : '0;

  // When lane 0 is bypassed straight to decode, the remaining lanes shift down one slot.
  for (genvar i = 0; i < int'(FETCH_W); i++) begin : g_lane
    if (i == 0) begin : g_first
      assign lane_we[i] = push & ~byp_take;
    end else begin : g_rest
      assign lane_we[i] = push;
    end
    assign lane_addr[i*PTR_W +: PTR_W] = wr_ptr_q + PTR_W'(i) - PTR_W'(byp_take);
    assign lane_data[i*ENT_W +: ENT_W] = {fetch_pc + PC_W'(i * INST_BYTES),
                                          fetch_data[i*INST_W +: INST_W]};
  end

  pfq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .LANES (FETCH_W),
    .AW    (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (lane_we),
    .waddr_i (lane_addr),
    .wdata_i (lane_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_ent)
  );

  always_comb begin
    out_inst = '0;
    out_pc   = '0;
    if (!empty) begin
      out_pc   = head_ent[ENT_W-1 -: PC_W];
      out_inst = head_ent[INST_W-1:0];
    end else if (byp_active) begin
      out_pc   = fetch_pc;
      out_inst = fetch_data[INST_W-1:0];
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
    count_d  = count_q + n_wr - CNT_W'(pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
// ============================================================================
// Module : tb_inst_prefetch_queue
// Brief  : Directed + short random stimulus with an in-order scoreboard for the queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_prefetch_queue;
  import nq_pfq_pkg::*;

  localparam int DEPTH   = 8;
  localparam int FETCH_W = 2;
  localparam int INST_W  = 16;
  localparam int PC_W    = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic                      fetch_valid;
  logic                      fetch_ready;
  logic [FETCH_W*INST_W-1:0] fetch_data;
  logic [PC_W-1:0]           fetch_pc;
  logic                      out_valid;
  logic                      out_ready;
  logic [INST_W-1:0]         out_inst;
  logic [PC_W-1:0]           out_pc;
  logic [3:0]                count;
  logic                      empty;
  logic                      full;

  int n_cmp = 0;
  int n_err = 0;

  inst_prefetch_queue #(
    .INST_W     (16),
    .PC_W       (32),
    .FETCH_W    (2),
    .DEPTH      (8),
    .INST_BYTES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .fetch_pc    (fetch_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  // Reference model: occupancy and ordered contents of the queue.
  pfq_entry_t sbq[$];
  pfq_entry_t ent;
  int         mcnt = 0;
  bit         exp_rdy;
  bit         exp_vld;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      mcnt = 0;
    end else begin
      exp_rdy = ((DEPTH - mcnt) >= FETCH_W) && !flush;
      exp_vld = (mcnt != 0);
`ifdef PFQ_BYPASS_EN
      if (mcnt == 0 && fetch_valid && exp_rdy) exp_vld = 1'b1;
`endif
      check("fetch_ready", 64'(fetch_ready), 64'(exp_rdy));
      check("out_valid",   64'(out_valid),   64'(exp_vld));
      check("count",       64'(count),       64'(mcnt));
      check("empty",       64'(empty),       64'(mcnt == 0));
      check("full",        64'(full),        64'(mcnt == DEPTH));
      if (flush) begin
        sbq.delete();
      end else begin
        if (fetch_valid && exp_rdy) begin
          for (int i = 0; i < FETCH_W; i++) begin
            ent.inst = fetch_data[i*INST_W +: INST_W];
            ent.pc   = fetch_pc + 32'(i * 2);
            sbq.push_back(ent);
          end
        end
        if (exp_vld) begin
          if (sbq.size() > 0) begin
            check("out_inst", 64'(out_inst), 64'(sbq[0].inst));
            check("out_pc",   64'(out_pc),   64'(sbq[0].pc));
            if (out_ready) void'(sbq.pop_front());
          end
        end else begin
          check("out_inst_idle", 64'(out_inst), 64'h0);
          check("out_pc_idle",   64'(out_pc),   64'h0);
        end
      end
      mcnt = sbq.size();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int acc_k;
  bit acc;

  initial begin
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_data = '0; fetch_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    smp();
    check("rst_fetch_ready", 64'(fetch_ready), 64'h0);
    check("rst_count",       64'(count),       64'h0);
    check("rst_out_valid",   64'(out_valid),   64'h0);
    check("rst_out_inst",    64'(out_inst),    64'h0);
    check("rst_out_pc",      64'(out_pc),      64'h0);
    check("rst_empty",       64'(empty),       64'h1);
    nxt();
    rst = 1'b0;

    // 1: single beat, decode always ready
    out_ready = 1'b1;
    fetch_data = {16'hB222, 16'hA111}; fetch_pc = 32'h100; fetch_valid = 1'b1;
    nxt();
    fetch_valid = 1'b0;
    smp();
`ifdef PFQ_BYPASS_EN
    check("t1_second_inst", 64'(out_inst), 64'hB222);
    check("t1_second_pc",   64'(out_pc),   64'h102);
`else
    check("t1_first_inst",  64'(out_inst), 64'hA111);
    check("t1_first_pc",    64'(out_pc),   64'h100);
    nxt(); smp();
    check("t1_second_inst", 64'(out_inst), 64'hB222);
    check("t1_second_pc",   64'(out_pc),   64'h102);
`endif
    nxt(); smp();
    check("t1_drained_valid", 64'(out_valid), 64'h0);
    check("t1_drained_empty", 64'(empty),     64'h1);
    nxt();

    // 2: fill to full with decode stalled; fifth beat must wait for two pops
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      fetch_data  = {16'(16'h2001 + 2*b), 16'(16'h2000 + 2*b)};
      fetch_pc    = 32'h1000 + 32'(4*b);
      fetch_valid = 1'b1;
      nxt();
    end
    fetch_data = {16'h2009, 16'h2008}; fetch_pc = 32'h1010;
    smp();
    check("t2_count_full", 64'(count),       64'h8);
    check("t2_full",       64'(full),        64'h1);
    check("t2_not_ready",  64'(fetch_ready), 64'h0);
    nxt(); smp();
    check("t2_held_not_ready", 64'(fetch_ready), 64'h0);
    nxt();
    out_ready = 1'b1;
    acc = 1'b0; acc_k = 0;
    while (!acc && acc_k < 10) begin
      smp();
      acc = fetch_ready;
      nxt();
      if (!acc) acc_k++;
    end
    fetch_valid = 1'b0;
    check("t2_fifth_after_two_pops", 64'(acc_k), 64'h2);
    repeat (12) nxt();
    smp();
    check("t2_drained", 64'(empty), 64'h1);
    nxt();

    // 3: stall holds the head stable; lane 1 pc wraps past 2^32
    out_ready = 1'b0;
    fetch_data = {16'h3333, 16'h3332}; fetch_pc = 32'hFFFF_FFFE; fetch_valid = 1'b1;
    nxt();
    fetch_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      smp();
      check("t3_stall_valid", 64'(out_valid), 64'h1);
      check("t3_stall_inst",  64'(out_inst),  64'h3332);
      check("t3_stall_pc",    64'(out_pc),    64'hFFFF_FFFE);
      nxt();
    end
    out_ready = 1'b1;
    repeat (3) nxt();
    smp();
    check("t3_drained", 64'(empty), 64'h1);
    nxt();

    // 4: fill, pop 7 of 8, push again so storage wraps
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      fetch_data  = {16'(16'h4001 + 2*b), 16'(16'h4000 + 2*b)};
      fetch_pc    = 32'h4000 + 32'(4*b);
      fetch_valid = 1'b1;
      nxt();
    end
    fetch_valid = 1'b0;
    smp();
    check("t4_count_full", 64'(count), 64'h8);
    nxt();
    out_ready = 1'b1;
    repeat (7) nxt();
    out_ready = 1'b0;
    fetch_data = {16'h4009, 16'h4008}; fetch_pc = 32'h4010; fetch_valid = 1'b1;
    nxt();
    fetch_valid = 1'b0;
    smp();
    check("t4_count_after_wrap_push", 64'(count), 64'h3);
    nxt();
    out_ready = 1'b1;
    repeat (4) nxt();
    smp();
    check("t4_drained", 64'(empty), 64'h1);
    nxt();

    // 5: flush with simultaneous push and pop
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      fetch_data  = {16'(16'h5001 + 2*b), 16'(16'h5000 + 2*b)};
      fetch_pc    = 32'h5000 + 32'(4*b);
      fetch_valid = 1'b1;
      nxt();
    end
    fetch_valid = 1'b0;
    smp();
    check("t5_count_before", 64'(count), 64'h4);
    nxt();
    flush = 1'b1; out_ready = 1'b1;
    fetch_data = {16'hEEEE, 16'hEEEE}; fetch_pc = 32'hE00; fetch_valid = 1'b1;
    nxt();
    flush = 1'b0; fetch_valid = 1'b0;
    smp();
    check("t5_count_flushed", 64'(count),     64'h0);
    check("t5_valid_flushed", 64'(out_valid), 64'h0);
    repeat (3) nxt();
    smp();
    check("t5_nothing_leaks", 64'(out_valid), 64'h0);
    nxt();

    // 6: push into empty queue with decode ready
    out_ready = 1'b1;
    fetch_data = {16'h00D4, 16'h00C3}; fetch_pc = 32'h200; fetch_valid = 1'b1;
    smp();
`ifdef PFQ_BYPASS_EN
    check("t6_bypass_valid", 64'(out_valid), 64'h1);
    check("t6_bypass_inst",  64'(out_inst),  64'h00C3);
    check("t6_bypass_pc",    64'(out_pc),    64'h200);
`else
    check("t6_same_cycle_valid", 64'(out_valid), 64'h0);
`endif
    nxt();
    fetch_valid = 1'b0;
    smp();
`ifdef PFQ_BYPASS_EN
    check("t6_next_inst", 64'(out_inst), 64'h00D4);
    check("t6_next_pc",   64'(out_pc),   64'h202);
    check("t6_count",     64'(count),    64'h1);
`else
    check("t6_next_inst", 64'(out_inst), 64'h00C3);
    check("t6_next_pc",   64'(out_pc),   64'h200);
    check("t6_count",     64'(count),    64'h2);
`endif
    repeat (3) nxt();

    // asynchronous reset while holding data
    out_ready = 1'b0;
    fetch_data = {16'h6001, 16'h6000}; fetch_pc = 32'h600; fetch_valid = 1'b1;
    nxt(); nxt();
    fetch_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_count",       64'(count),       64'h0);
    check("mid_rst_out_valid",   64'(out_valid),   64'h0);
    check("mid_rst_fetch_ready", 64'(fetch_ready), 64'h0);
    check("mid_rst_out_inst",    64'(out_inst),    64'h0);
    nxt();
    rst = 1'b0;
    nxt();

    // short random traffic with occasional flushes
    for (int c = 0; c < 80; c++) begin
      fetch_valid = 1'($urandom_range(0, 1));
      fetch_data  = 32'($urandom);
      fetch_pc    = 32'($urandom) & 32'hFFFF_FFFE;
      out_ready   = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 15) == 0);
      nxt();
    end
    fetch_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (10) nxt();
    smp();
    check("rand_drained", 64'(empty), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
